flag_marker: RTL and testbench

Writer side of the per-tile flag arrays consumed by the board flag-drawing stage. Converts a right-click mouse position into a tile column/row and toggles that tile's flag. Keeps the easy/medium/hard flag arrays and a running flag count; sits between the mouse-control block and the redraw-board pipeline. Tile coordinates come from an iterative-subtraction divider, so no hardware divider is needed.

---
 rtl/flag_marker_if.sv | 9 +
 rtl/flag_marker.sv | 131 +++++++++++++
 tb/tb_flag_marker.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/flag_marker_if.sv
// game_set_if: board geometry for the flag writer (board origin, tile size in pixels, tiles per side)
interface game_set_if;
  logic [10:0] board_xpos;
  logic [10:0] board_ypos;
  logic [7:0]  button_size;
  logic [4:0]  button_num;
  modport in  (input  board_xpos, board_ypos, button_size, button_num);
  modport out (output board_xpos, board_ypos, button_size, button_num);
endinterface

// File: rtl/flag_marker.sv
// flag_marker: turns a right-click position into a tile and toggles its flag
// Ports: clk/rst_n clock and async active-low reset; gin board geometry;
// mouse_xpos/mouse_ypos pixel position; right button level; new_game clears all;
// max_flags flag limit; flag_arr_* per-difficulty [col][row] flag arrays;
// flag_count flags set; busy not idle; done toggle applied; rejected click discarded.
module flag_marker (
  input  logic              clk,
  input  logic              rst_n,
  game_set_if.in            gin,
  input  logic [10:0]       mouse_xpos,
  input  logic [10:0]       mouse_ypos,
  input  logic              right,
  input  logic              new_game,
  input  logic [7:0]        max_flags,
  output logic [7:0][7:0]   flag_arr_easy,
  output logic [9:0][9:0]   flag_arr_medium,
  output logic [15:0][15:0] flag_arr_hard,
  output logic [7:0]        flag_count,
  output logic              busy,
  output logic              done,
  output logic              rejected
);
  typedef enum logic [1:0] {IDLE, CHECK, DIV, UPDATE} state_t;
  state_t           r_state;
  logic             r_right_d, r_lo_x, r_lo_y, r_done, r_rejected;
  logic [10:0]      r_off_x, r_off_y, r_span, r_rem_x, r_rem_y;
  logic [4:0]       r_col, r_row;
  logic [7:0]       r_count;
  logic [7:0][7:0]  r_easy;
  logic [9:0][9:0]  r_med;
  logic [15:0][15:0] r_hard;
  logic             w_click, w_step_x, w_step_y, w_easy, w_med, w_hard, w_cur;
  logic [10:0]      w_size, w_span;
  logic [12:0]      w_prod;
  always_comb begin
    w_click  = right && !r_right_d;
    w_size   = {3'b0, gin.button_size};
    w_prod   = {8'b0, gin.button_num} * {5'b0, gin.button_size};
    w_span   = w_prod[10:0];
    w_step_x = r_rem_x >= w_size;
    w_step_y = r_rem_y >= w_size;
    w_easy   = gin.button_num == 5'd8;
    w_med    = gin.button_num == 5'd10;
    w_hard   = gin.button_num == 5'd16;
    w_cur    = w_easy ? r_easy[r_col[2:0]][r_row[2:0]] :
               w_med  ? r_med[r_col[3:0]][r_row[3:0]] :
               w_hard ? r_hard[r_col[3:0]][r_row[3:0]] : 1'b0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_right_d  <= 1'b0;
      r_lo_x     <= 1'b0;
      r_lo_y     <= 1'b0;
      r_done     <= 1'b0;
      r_rejected <= 1'b0;
      r_off_x    <= '0;
      r_off_y    <= '0;
      r_span     <= '0;
      r_rem_x    <= '0;
      r_rem_y    <= '0;
      r_col      <= '0;
      r_row      <= '0;
      r_count    <= '0;
      r_easy     <= '0;
      r_med      <= '0;
      r_hard     <= '0;
    end else begin
      r_right_d  <= right;
      r_done     <= 1'b0;
      r_rejected <= 1'b0;
      if (new_game) begin
        r_state <= IDLE;
        r_count <= '0;
        r_easy  <= '0;
        r_med   <= '0;
        r_hard  <= '0;
      end else begin
        case (r_state)
          IDLE: if (w_click) begin
            r_off_x <= mouse_xpos - gin.board_xpos;
            r_off_y <= mouse_ypos - gin.board_ypos;
            r_lo_x  <= mouse_xpos < gin.board_xpos;
            r_lo_y  <= mouse_ypos < gin.board_ypos;
            r_span  <= w_span;
            r_state <= CHECK;
          end
          CHECK: if (r_lo_x || r_lo_y || r_off_x >= r_span || r_off_y >= r_span) begin
            r_rejected <= 1'b1;
            r_state    <= IDLE;
          end else begin
            r_col   <= '0;
            r_row   <= '0;
            r_rem_x <= r_off_x;
            r_rem_y <= r_off_y;
            r_state <= DIV;
          end
          DIV: begin
            if (w_step_x) begin
              r_rem_x <= r_rem_x - w_size;
              r_col   <= r_col + 5'd1;
            end
            if (w_step_y) begin
              r_rem_y <= r_rem_y - w_size;
              r_row   <= r_row + 5'd1;
            end
            if (!w_step_x && !w_step_y) r_state <= UPDATE;
          end
          UPDATE: begin
            r_state <= IDLE;
            if (!(w_easy || w_med || w_hard) || (!w_cur && r_count >= max_flags)) r_rejected <= 1'b1;
            else begin
              r_done  <= 1'b1;
              r_count <= w_cur ? r_count - 8'd1 : r_count + 8'd1;
              if (w_easy) r_easy[r_col[2:0]][r_row[2:0]] <= !w_cur;
              if (w_med)  r_med[r_col[3:0]][r_row[3:0]]  <= !w_cur;
              if (w_hard) r_hard[r_col[3:0]][r_row[3:0]] <= !w_cur;
            end
          end
        endcase
      end
    end
  end
  assign flag_arr_easy   = r_easy;
  assign flag_arr_medium = r_med;
  assign flag_arr_hard   = r_hard;
  assign flag_count      = r_count;
  assign busy            = r_state != IDLE;
  assign done            = r_done;
  assign rejected        = r_rejected;
endmodule

// File: tb/tb_flag_marker.sv
// tb_flag_marker: directed self-checking bench for flag_marker
module tb_flag_marker;
  logic clk = 0, rst_n = 0, right = 0, new_game = 0;
  logic [10:0] mouse_xpos = 0, mouse_ypos = 0;
  logic [7:0] max_flags = 8'd40;
  logic [7:0][7:0] flag_arr_easy;
  logic [9:0][9:0] flag_arr_medium;
  logic [15:0][15:0] flag_arr_hard;
  logic [7:0] flag_count;
  logic busy, done, rejected;
  int n_cmp = 0, n_bad = 0;
  game_set_if g();
  flag_marker dut (
    .clk(clk), .rst_n(rst_n), .gin(g.in), .mouse_xpos(mouse_xpos), .mouse_ypos(mouse_ypos),
    .right(right), .new_game(new_game), .max_flags(max_flags),
    .flag_arr_easy(flag_arr_easy), .flag_arr_medium(flag_arr_medium), .flag_arr_hard(flag_arr_hard),
    .flag_count(flag_count), .busy(busy), .done(done), .rejected(rejected)
  );
  always #5 clk = ~clk;
  logic [7:0][7:0] exp_easy;
  logic [9:0][9:0] exp_med;
  logic [15:0][15:0] exp_hard;
  int lat;
  logic got_done, got_rej, busy_t1, busy_end;

  task automatic set_gin(input int x, input int y, input int s, input int n);
    g.board_xpos = 11'(x);
    g.board_ypos = 11'(y);
    g.button_size = 8'(s);
    g.button_num = 5'(n);
  endtask

  task automatic click(input int x, input int y, input bit hold);
    @(negedge clk);
    mouse_xpos = 11'(x);
    mouse_ypos = 11'(y);
    right = 1;
    @(posedge clk);
    @(negedge clk);
    busy_t1 = busy;
    if (!hold) right = 0;
    lat = 0; got_done = 0; got_rej = 0; busy_end = 1;
    for (int c = 1; c <= 40 && lat == 0; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (done || rejected) begin
        lat = c + 1;
        got_done = done;
        got_rej = rejected;
        busy_end = busy;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({flag_count, busy, done, rejected} !== 11'd0 || flag_arr_easy !== '0 || flag_arr_medium !== '0 || flag_arr_hard !== '0) begin
      n_bad++;
      $display("FAIL reset: count=%0d busy=%b done=%b rej=%b, required all zero", flag_count, busy, done, rejected);
    end
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_basic_set;
    set_gin(100, 80, 40, 8);
    click(185, 125, 0);
    exp_easy = '0; exp_easy[2][1] = 1'b1;
    n_cmp++;
    if (!got_done || got_rej || lat != 6) begin
      n_bad++; $display("FAIL basic_set_timing: done=%b rej=%b lat=%0d, required done lat=6", got_done, got_rej, lat);
    end
    n_cmp++;
    if (flag_arr_easy !== exp_easy || flag_count !== 8'd1) begin
      n_bad++; $display("FAIL basic_set_state: easy=%h count=%0d, required easy=%h count=1", flag_arr_easy, flag_count, exp_easy);
    end
    n_cmp++;
    if (busy_t1 !== 1'b1 || busy_end !== 1'b0) begin
      n_bad++; $display("FAIL basic_set_busy: at T+1=%b at done=%b, required 1 then 0", busy_t1, busy_end);
    end
  endtask

  task automatic test_toggle_clear;
    click(185, 125, 0);
    n_cmp++;
    if (!got_done || lat != 6 || flag_arr_easy !== '0 || flag_count !== 8'd0) begin
      n_bad++; $display("FAIL toggle_clear: done=%b lat=%0d easy=%h count=%0d, required done lat=6 easy=0 count=0", got_done, lat, flag_arr_easy, flag_count);
    end
  endtask

  task automatic test_out_of_bounds;
    int xs[3] = '{99, 420, 185};
    int ys[3] = '{125, 125, 79};
    for (int i = 0; i < 3; i++) begin
      click(xs[i], ys[i], 0);
      n_cmp++;
      if (!got_rej || got_done || lat != 2 || flag_arr_easy !== '0 || flag_count !== 8'd0) begin
        n_bad++; $display("FAIL oob_%0d: rej=%b done=%b lat=%0d count=%0d, required rej lat=2 no change", i, got_rej, got_done, lat, flag_count);
      end
    end
  endtask

  task automatic test_flag_limit;
    max_flags = 8'd1;
    click(185, 125, 0);
    click(105, 85, 0);
    exp_easy = '0; exp_easy[2][1] = 1'b1;
    n_cmp++;
    if (!got_rej || got_done || lat != 4) begin
      n_bad++; $display("FAIL limit_reject: rej=%b done=%b lat=%0d, required rej lat=4", got_rej, got_done, lat);
    end
    n_cmp++;
    if (flag_arr_easy !== exp_easy || flag_count !== 8'd1) begin
      n_bad++; $display("FAIL limit_state: easy=%h count=%0d, required easy=%h count=1", flag_arr_easy, flag_count, exp_easy);
    end
    max_flags = 8'd40;
  endtask

  task automatic test_unsupported;
    set_gin(100, 80, 20, 12);
    click(105, 85, 0);
    n_cmp++;
    if (!got_rej || got_done || lat != 4 || flag_count !== 8'd1 || flag_arr_easy !== exp_easy) begin
      n_bad++; $display("FAIL unsupported_num: rej=%b done=%b lat=%0d count=%0d, required rej lat=4 count=1", got_rej, got_done, lat, flag_count);
    end
  endtask

  task automatic test_medium;
    set_gin(100, 80, 32, 10);
    click(389, 176, 0);
    exp_med = '0; exp_med[9][3] = 1'b1;
    n_cmp++;
    if (!got_done || lat != 13 || flag_arr_medium !== exp_med || flag_count !== 8'd2) begin
      n_bad++; $display("FAIL medium_set: done=%b lat=%0d med=%h count=%0d, required done lat=13 med=%h count=2", got_done, lat, flag_arr_medium, flag_count, exp_med);
    end
    n_cmp++;
    if (flag_arr_easy !== exp_easy || flag_arr_hard !== '0) begin
      n_bad++; $display("FAIL medium_isolation: easy=%h hard=%h, required easy=%h hard=0", flag_arr_easy, flag_arr_hard, exp_easy);
    end
  endtask

  task automatic test_hard_corner;
    set_gin(100, 80, 25, 16);
    click(478, 458, 0);
    exp_hard = '0; exp_hard[15][15] = 1'b1;
    n_cmp++;
    if (!got_done || lat != 19 || flag_arr_hard !== exp_hard || flag_count !== 8'd3) begin
      n_bad++; $display("FAIL hard_corner: done=%b lat=%0d hard=%h count=%0d, required done lat=19 count=3", got_done, lat, flag_arr_hard, flag_count);
    end
    n_cmp++;
    if (flag_arr_easy !== exp_easy || flag_arr_medium !== exp_med) begin
      n_bad++; $display("FAIL hard_isolation: easy=%h med=%h, required easy=%h med=%h", flag_arr_easy, flag_arr_medium, exp_easy, exp_med);
    end
  endtask

  task automatic test_held_click;
    set_gin(100, 80, 40, 8);
    click(305, 85, 1);
    exp_easy[5][0] = 1'b1;
    n_cmp++;
    if (!got_done || lat != 9 || flag_arr_easy !== exp_easy || flag_count !== 8'd4) begin
      n_bad++; $display("FAIL held_first: done=%b lat=%0d easy=%h count=%0d, required done lat=9 easy=%h count=4", got_done, lat, flag_arr_easy, flag_count, exp_easy);
    end
    got_done = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (busy || done || rejected) got_done = 1;
    end
    n_cmp++;
    if (got_done || flag_count !== 8'd4) begin
      n_bad++; $display("FAIL held_no_repeat: activity=%b count=%0d, required no activity count=4", got_done, flag_count);
    end
    right = 0;
    @(negedge clk);
  endtask

  task automatic test_abort;
    @(negedge clk);
    mouse_xpos = 11'd385;
    mouse_ypos = 11'd365;
    right = 1;
    @(posedge clk);
    repeat (4) @(negedge clk);
    new_game = 1;
    @(negedge clk);
    new_game = 0;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || rejected !== 1'b0) begin
      n_bad++; $display("FAIL abort_cycle: busy=%b done=%b rej=%b, required 0 0 0", busy, done, rejected);
    end
    got_done = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (busy || done || rejected) got_done = 1;
    end
    n_cmp++;
    if (got_done || flag_count !== 8'd0 || flag_arr_easy !== '0 || flag_arr_medium !== '0 || flag_arr_hard !== '0) begin
      n_bad++; $display("FAIL abort_state: activity=%b count=%0d, required idle with arrays and count 0", got_done, flag_count);
    end
    right = 0;
    @(negedge clk);
    click(385, 365, 0);
    exp_easy = '0; exp_easy[7][7] = 1'b1;
    n_cmp++;
    if (!got_done || lat != 11 || flag_arr_easy !== exp_easy || flag_count !== 8'd1) begin
      n_bad++; $display("FAIL after_abort: done=%b lat=%0d count=%0d, required done lat=11 count=1", got_done, lat, flag_count);
    end
  endtask

  initial begin
    set_gin(100, 80, 40, 8);
    test_reset;
    test_basic_set;
    test_toggle_clear;
    test_out_of_bounds;
    test_flag_limit;
    test_unsupported;
    test_medium;
    test_hard_corner;
    test_held_click;
    test_abort;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
